// File: rtl/stats_pkg.sv
// ============================================================================
// stats_pkg : shared types and sizing helpers for the statistics sequencer
// Rev 1.0   : initial release
// ============================================================================
`default_nettype none

package stats_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DIV   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int DATA_W_DEF = 12;
    localparam int ADDR_W_DEF = 7;

    // Accumulator width that can hold SAMPLES full-scale words without overflow.
    function automatic int sum_width(input int data_w, input int samples);
        return data_w + $clog2(samples);
    endfunction

endpackage

`default_nettype wire

// File: rtl/serial_divider.sv
// ============================================================================
// serial_divider : restoring divider, one quotient bit per cycle, N_W cycles
// Rev 1.0        : initial release
// ============================================================================
`default_nettype none

module serial_divider #(
    parameter int N_W = 19,
    parameter int D_W = 7
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           go,
    input  logic [N_W-1:0] dividend,
    input  logic [D_W-1:0] divisor,
    output logic [N_W-1:0] quotient,
    output logic           ready
);

    localparam int CNT_W = $clog2(N_W + 1);

    logic [N_W-1:0]   num_q, num_d;
    logic [D_W-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;

    logic [N_W-1:0]   w_num_src;
    logic [D_W-1:0]   w_rem_src;
    logic [D_W:0]     w_trial;
    logic             w_fits;

    // The go cycle already performs the first step, so the last bit lands
    // exactly N_W cycles after go; quotient is the post-step value.
    always_comb begin
        w_num_src = go ? dividend : num_q;
        w_rem_src = go ? '0 : rem_q;
        w_trial   = {w_rem_src, w_num_src[N_W-1]};
        w_fits    = (w_trial >= {1'b0, divisor});
        num_d     = num_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        run_d     = run_q;
        ready     = 1'b0;
        if (go || run_q) begin
            num_d = {w_num_src[N_W-2:0], w_fits};
            rem_d = w_fits ? D_W'(w_trial - {1'b0, divisor}) : w_trial[D_W-1:0];
            cnt_d = go ? CNT_W'(1) : cnt_q + CNT_W'(1);
            ready = (cnt_d == CNT_W'(N_W));
            run_d = !ready;
        end
    end

    assign quotient = num_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_q <= '0;
            rem_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            num_q <= num_d;
            rem_q <= rem_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/stats_sequencer.sv
// ============================================================================
// stats_sequencer : walks the capture buffer and reports average / min / max
// Rev 1.0         : initial release
// ============================================================================
`default_nettype none

module stats_sequencer
    import stats_pkg::*;
#(
    parameter int SAMPLES = 80,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              valid,
    output logic [DATA_W-1:0] average,
    output logic [DATA_W-1:0] min,
    output logic [DATA_W-1:0] max
);

    localparam int SUM_W = sum_width(DATA_W, SAMPLES);
    localparam int DIV_W = $clog2(SAMPLES + 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SAMPLES - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              vld_q;
    logic              first_q, first_d;
    logic              go_q;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] avg_q, avg_d;
    logic [DATA_W-1:0] min_q, min_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic              valid_q, valid_d;

    logic [SUM_W-1:0]  div_quot;
    logic              div_ready;

    serial_divider #(
        .N_W (SUM_W),
        .D_W (DIV_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .go       (go_q),
        .dividend (sum_q),
        .divisor  (DIV_W'(SAMPLES)),
        .quotient (div_quot),
        .ready    (div_ready)
    );

    // The quotient never exceeds full-scale, so its upper bits are always zero.
    if (SUM_W > DATA_W) begin : g_quot_hi
        logic unused_quot_hi;
        assign unused_quot_hi = ^div_quot[SUM_W-1:DATA_W];
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        first_d = first_q;
        sum_d   = sum_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        avg_d   = avg_q;
        min_d   = min_q;
        max_d   = max_q;
        valid_d = valid_q;

        if (vld_q) begin
            sum_d   = sum_q + SUM_W'(rd_data);
            first_d = 1'b0;
            if (first_q || (rd_data < lo_q)) lo_d = rd_data;
            if (first_q || (rd_data > hi_q)) hi_d = rd_data;
        end

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d = ST_READ;
                    idx_d   = '0;
                    sum_d   = '0;
                    first_d = 1'b1;
                end
            end
            ST_READ: begin
                idx_d = idx_q + ADDR_W'(1);
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: state_d = ST_DIV;
            ST_DIV: begin
                if (div_ready) begin
                    state_d = ST_DONE;
                    avg_d   = div_quot[DATA_W-1:0];
                    min_d   = lo_q;
                    max_d   = hi_q;
                    valid_d = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides every transition and discards a result in flight.
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            avg_d   = avg_q;
            min_d   = min_q;
            max_d   = max_q;
            valid_d = valid_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            vld_q   <= 1'b0;
            first_q <= 1'b0;
            go_q    <= 1'b0;
            sum_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            avg_q   <= '0;
            min_q   <= '0;
            max_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vld_q   <= (state_q == ST_READ);
            first_q <= first_d;
            go_q    <= (state_q == ST_DRAIN) && !abort;
            sum_q   <= sum_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            avg_q   <= avg_d;
            min_q   <= min_d;
            max_q   <= max_d;
            valid_q <= valid_d;
        end
    end

    assign rd_en   = (state_q == ST_READ);
    assign rd_addr = idx_q;
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign valid   = valid_q;
    assign average = avg_q;
    assign min     = min_q;
    assign max     = max_q;

endmodule

`default_nettype wire

// File: tb/tb_stats_sequencer.sv
// ============================================================================
// tb_stats_sequencer : cycle-accurate self-checking bench for stats_sequencer
// Rev 1.0            : initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_stats_sequencer;

    localparam int SAMPLES  = 80;
    localparam int DATA_W   = 12;
    localparam int ADDR_W   = 7;
    localparam int SUM_W    = DATA_W + $clog2(SAMPLES);
    localparam int DONE_CYC = SAMPLES + SUM_W + 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data = '0;
    logic              busy, done, valid;
    logic [DATA_W-1:0] average, min_o, max_o;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int n_checks = 0;
    int n_errors = 0;
    int cur_cyc  = 0;
    int cm_avg = 0, cm_min = 0, cm_max = 0, cm_valid = 0;

    stats_sequencer #(
        .SAMPLES (SAMPLES),
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .busy    (busy),
        .done    (done),
        .valid   (valid),
        .average (average),
        .min     (min_o),
        .max     (max_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cur_cyc, got, exp);
        end
    endtask

    task automatic model(output int avg, output int mn, output int mx);
        int sum;
        sum = 0;
        mn  = (1 << DATA_W) - 1;
        mx  = 0;
        for (int i = 0; i < SAMPLES; i++) begin
            sum += int'(mem[i]);
            if (int'(mem[i]) < mn) mn = int'(mem[i]);
            if (int'(mem[i]) > mx) mx = int'(mem[i]);
        end
        avg = sum / SAMPLES;
    endtask

    task automatic check_outputs();
        chk("average", 32'(average), 32'(cm_avg));
        chk("min",     32'(min_o),   32'(cm_min));
        chk("max",     32'(max_o),   32'(cm_max));
        chk("valid",   32'(valid),   32'(cm_valid));
    endtask

    // One measurement, checked cycle by cycle from the start cycle onward.
    task automatic do_run(input int abort_at, input int rst_at, input bit extra_starts);
        int  m_avg, m_min, m_max, last;
        bit  active;
        model(m_avg, m_min, m_max);
        @(negedge clk);
        cur_cyc = 0;
        start   = 1'b1;
        abort   = 1'b0;
        chk("busy_c0", 32'(busy), 32'd0);
        last = (abort_at > 0) ? abort_at + 1 : ((rst_at > 0) ? rst_at : DONE_CYC + 1);
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            cur_cyc = c;
            start   = extra_starts && (c == 5 || c == 90);
            abort   = (c == abort_at);
            active  = (abort_at == 0) || (c <= abort_at);
            chk("rd_en", 32'(rd_en), 32'(active && c <= SAMPLES));
            if (active && c <= SAMPLES) chk("rd_addr", 32'(rd_addr), 32'(c - 1));
            chk("busy", 32'(busy), 32'(active && c <= DONE_CYC));
            chk("done", 32'(done), 32'(active && c == DONE_CYC));
            if (active && c == DONE_CYC) begin
                cm_avg   = m_avg;
                cm_min   = m_min;
                cm_max   = m_max;
                cm_valid = 1;
            end
            check_outputs();
            if (c == rst_at) begin
                #2 rst = 1'b1;
                #1;
                cm_avg = 0; cm_min = 0; cm_max = 0; cm_valid = 0;
                chk("rst_rd_en", 32'(rd_en), 32'd0);
                chk("rst_rd_addr", 32'(rd_addr), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                check_outputs();
                @(negedge clk);
                rst = 1'b0;
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < SAMPLES; i++) mem[i] = DATA_W'(i);
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        #1 rst = 1'b1;
        #2;
        chk("reset_rd_en", 32'(rd_en), 32'd0);
        chk("reset_rd_addr", 32'(rd_addr), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        check_outputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        fill_ramp();
        do_run(0, 0, 1'b0);
        chk("ramp_avg", 32'(average), 32'd39);
        chk("ramp_min", 32'(min_o), 32'd0);
        chk("ramp_max", 32'(max_o), 32'd79);
        do_run(0, 0, 1'b1);

        for (int i = 0; i < SAMPLES; i++) mem[i] = 12'd4095;
        do_run(0, 0, 1'b0);
        chk("full_avg", 32'(average), 32'd4095);
        chk("full_min", 32'(min_o), 32'd4095);

        for (int i = 0; i < SAMPLES; i++) mem[i] = 12'd100;
        mem[40] = 12'd0;
        do_run(0, 0, 1'b0);
        chk("dip_avg", 32'(average), 32'd98);
        chk("dip_min", 32'(min_o), 32'd0);
        chk("dip_max", 32'(max_o), 32'd100);
        for (int i = 0; i < SAMPLES; i++) mem[i] = 12'd7;
        do_run(0, 0, 1'b0);

        fill_ramp();
        do_run(0, 0, 1'b0);
        do_run(50, 0, 1'b0);
        chk("abort_avg", 32'(average), 32'd39);
        chk("abort_valid", 32'(valid), 32'd1);
        do_run(0, 0, 1'b0);

        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", 32'(busy), 32'd0);
        chk("start_abort_rd_en", 32'(rd_en), 32'd0);

        do_run(0, 30, 1'b0);
        do_run(0, 0, 1'b0);
        chk("post_rst_avg", 32'(average), 32'd39);

        for (int r = 0; r < 8; r++) begin
            int unsigned span;
            span = (r % 2 == 0) ? 32'd4095 : $urandom_range(1, 300);
            for (int i = 0; i < SAMPLES; i++) mem[i] = DATA_W'($urandom_range(0, span));
            if (r % 3 == 2) do_run(int'($urandom_range(1, DONE_CYC)), 0, 1'b0);
            else            do_run(0, 0, r % 2 == 1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
